cbrt_share_ctrl: RTL and testbench

Round-robin controller that shares a single `cubic_root` engine between `N` requesters. It arbitrates among pending requests and issues the winner's 8-bit operand to the engine with a one-cycle start pulse. It tracks the engine's `busy` handshake and returns the 8-bit result to the granted requester with a one-cycle done pulse. It sits between the requesting blocks and the `cubic_root` instance, which stays a separate instance driven by this block's `cr_*` ports.

---
 rtl/cbrt_pkg.sv | 14 +
 rtl/cbrt_share_ctrl_if.sv | 29 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/cbrt_share_ctrl.sv | 145 ++++++++++++++
 tb/tb_cbrt_share_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cbrt_pkg.sv
// Shared types and widths for the cubic-root sharing controller.
package cbrt_pkg;

  localparam int unsigned CBRT_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StRun,
    StDone
  } cbrt_state_t;

endpackage

// File: rtl/cbrt_share_ctrl_if.sv
// Requester-side and engine-side signals of the shared cubic-root controller.
interface cbrt_share_ctrl_if #(
  parameter int unsigned N = 4
);
  import cbrt_pkg::*;

  logic [N-1:0]        req;
  logic [CBRT_W*N-1:0] x_in;
  logic [N-1:0]        ack;
  logic [N-1:0]        done;
  logic [CBRT_W-1:0]   y_out;
  logic                err;
  logic                cr_start;
  logic [CBRT_W-1:0]   cr_x;
  logic                cr_busy;
  logic [CBRT_W-1:0]   cr_y;

  // slave: the controller; master: requesters plus engine environment.
  modport slave (
    input  req, x_in, cr_busy, cr_y,
    output ack, done, y_out, err, cr_start, cr_x
  );

  modport master (
    output req, x_in, cr_busy, cr_y,
    input  ack, done, y_out, err, cr_start, cr_x
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping at N.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            any_o
);

  int unsigned cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    cand      = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(ptr_i) + i) % N;
      if (!any_o && req_i[IdxW'(cand)]) begin
        any_o                 = 1'b1;
        gnt_o[IdxW'(cand)]    = 1'b1;
        gnt_idx_o             = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/cbrt_share_ctrl.sv
// Shares one cubic_root engine among N requesters with round-robin grants,
// busy-handshake tracking and a timeout abort. All outputs are registered.
module cbrt_share_ctrl
  import cbrt_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  cbrt_share_ctrl_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  cbrt_state_t       state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CBRT_W-1:0] cr_x_q, cr_x_d;
  logic              cr_start_q, cr_start_d;
  logic [N-1:0]      ack_q, ack_d;
  logic [N-1:0]      done_q, done_d;
  logic [CBRT_W-1:0] y_out_q, y_out_d;
  logic              err_q, err_d;

  logic [N-1:0]      arb_gnt;
  logic [IdxW-1:0]   arb_idx;
  logic              arb_any;
  logic [CBRT_W-1:0] sel_x;
  logic              timeout_hit;

  rr_arbiter #(
    .N    (N),
    .IdxW (IdxW)
  ) u_arb (
    .req_i     (bus.req),
    .ptr_i     (ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .any_o     (arb_any)
  );

  always_comb begin
    sel_x = '0;
    for (int i = 0; i < N; i++) begin
      if (arb_gnt[i]) sel_x = bus.x_in[i*CBRT_W +: CBRT_W];
    end
  end

  // Total cycles in WaitBusy plus Run are capped at TIMEOUT.
  assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    cr_x_d     = cr_x_q;
    cr_start_d = 1'b0;
    ack_d      = '0;
    done_d     = '0;
    y_out_d    = '0;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          state_d    = StIssue;
          gnt_d      = arb_gnt;
          cr_x_d     = sel_x;
          ptr_d      = (arb_idx == IdxW'(N - 1)) ? '0 : arb_idx + IdxW'(1);
          cnt_d      = '0;
          cr_start_d = 1'b1;
          ack_d      = arb_gnt;
        end
      end
      StIssue: begin
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        cnt_d = cnt_q + CntW'(1);
        if (bus.cr_busy) begin
          state_d = StRun;
        end else if (timeout_hit) begin
          state_d = StDone;
          done_d  = gnt_q;
          err_d   = 1'b1;
        end
      end
      StRun: begin
        cnt_d = cnt_q + CntW'(1);
        if (!bus.cr_busy) begin
          state_d = StDone;
          done_d  = gnt_q;
          y_out_d = bus.cr_y;
        end else if (timeout_hit) begin
          state_d = StDone;
          done_d  = gnt_q;
          err_d   = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      gnt_q      <= '0;
      cnt_q      <= '0;
      cr_x_q     <= '0;
      cr_start_q <= 1'b0;
      ack_q      <= '0;
      done_q     <= '0;
      y_out_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      cr_x_q     <= cr_x_d;
      cr_start_q <= cr_start_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      y_out_q    <= y_out_d;
      err_q      <= err_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.done     = done_q;
  assign bus.y_out    = y_out_q;
  assign bus.err      = err_q;
  assign bus.cr_start = cr_start_q;
  assign bus.cr_x     = cr_x_q;

endmodule

// File: tb/tb_cbrt_share_ctrl.sv
// Bench for cbrt_share_ctrl: behavioural engine, round-robin scoreboard, vector table
// and directed sequences for ordering, fairness, timeout and reset.
module tb_cbrt_share_ctrl;
  import cbrt_pkg::*;

  localparam int unsigned N       = 4;
  localparam int unsigned TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cbrt_share_ctrl_if #(.N(N)) bus ();

  cbrt_share_ctrl #(
    .N       (N),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] cbrt_ref(input logic [7:0] x);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= int'(x)) r++;
    return 8'(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Engine environment: launches on start while idle, busy rises 1 or 2 cycles later.
  int   rise_late = 0;
  int   run_len   = 3;
  bit   eng_stuck = 1'b0;
  logic eng_busy;
  logic eng_pend;
  logic [7:0] eng_y;
  logic [7:0] eng_x;
  int   eng_cnt;
  int   eng_starts = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_busy <= 1'b0;
      eng_pend <= 1'b0;
      eng_y    <= 8'h00;
      eng_x    <= 8'h00;
      eng_cnt  <= 0;
    end else if (eng_pend) begin
      eng_pend <= 1'b0;
      eng_busy <= 1'b1;
    end else if (!eng_busy && bus.cr_start) begin
      eng_starts <= eng_starts + 1;
      eng_x      <= bus.cr_x;
      eng_y      <= 8'hA5;
      eng_cnt    <= run_len;
      if (rise_late != 0) eng_pend <= 1'b1;
      else eng_busy <= 1'b1;
    end else if (eng_busy && !eng_stuck) begin
      if (eng_cnt <= 1) begin
        eng_busy <= 1'b0;
        eng_y    <= cbrt_ref(eng_x);
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  assign bus.cr_busy = eng_busy;
  assign bus.cr_y    = eng_y;

  logic [N-1:0] req_at_edge = '0;
  always @(posedge clk) req_at_edge <= bus.req;

  // Scoreboard: grant order, operand routing, result and error of each service.
  int   model_ptr = 0;
  bit   pend_v = 1'b0;
  int   pend_g = 0;
  logic [7:0] pend_x = 8'h00;
  bit   exp_err = 1'b0;

  initial begin
    int g;
    int c;
    forever begin
      @(negedge clk);
      if (reset) begin
        model_ptr = 0;
        pend_v    = 1'b0;
      end else begin
        if (bus.ack != 0) begin
          g = -1;
          for (int i = 0; i < N; i++) begin
            c = (model_ptr + i) % N;
            if (g < 0 && req_at_edge[c]) g = c;
          end
          if (g < 0) begin
            check("ack_without_req", 32'(bus.ack), 0);
          end else begin
            check("ack_rr", 32'(bus.ack), 32'(1) << g);
            check("cr_start_with_ack", 32'(bus.cr_start), 1);
            check("cr_x", 32'(bus.cr_x), 32'(bus.x_in[g*8 +: 8]));
            check("ack_vs_done", 32'(bus.done), 0);
            pend_v    = 1'b1;
            pend_g    = g;
            pend_x    = bus.x_in[g*8 +: 8];
            model_ptr = (g + 1) % N;
          end
        end else if (bus.cr_start) begin
          check("start_without_ack", 32'(bus.cr_start), 0);
        end
        if (bus.done != 0) begin
          if (!pend_v) begin
            check("done_unexpected", 32'(bus.done), 0);
          end else begin
            check("done_onehot", 32'(bus.done), 32'(1) << pend_g);
            check("err", 32'(bus.err), 32'(exp_err));
            check("y_out", 32'(bus.y_out), exp_err ? 0 : 32'(cbrt_ref(pend_x)));
            pend_v = 1'b0;
          end
        end
      end
    end
  end

  task automatic set_x(input int g, input logic [7:0] x);
    bus.x_in[g*8 +: 8] = x;
  endtask

  task automatic wait_ack_any(output int got, output int cyc);
    got = -1;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.ack != 0) begin
        got = $clog2(bus.ack);
        break;
      end
    end
    if (got < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_wait actual=none required=ack");
    end
  endtask

  task automatic wait_done(output int cyc, output logic [7:0] y, output logic e);
    bit seen = 1'b0;
    cyc = 0;
    y   = 8'h00;
    e   = 1'b0;
    for (int i = 0; i < int'(TIMEOUT) + 40; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.done != 0) begin
        y    = bus.y_out;
        e    = bus.err;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_wait actual=none required=done");
    end
  endtask

  task automatic serve_one(input int g, input logic [7:0] x,
                           output logic [7:0] y, output logic e, output int lat);
    int got;
    int cyc;
    set_x(g, x);
    bus.req[g] = 1'b1;
    wait_ack_any(got, cyc);
    bus.req[g] = 1'b0;
    check("grant_single", 32'(got), 32'(g));
    wait_done(lat, y, e);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"}, 32'(bus.ack), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_y_out"}, 32'(bus.y_out), 0);
    check({tag, "_err"}, 32'(bus.err), 0);
    check({tag, "_cr_start"}, 32'(bus.cr_start), 0);
    check({tag, "_cr_x"}, 32'(bus.cr_x), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    int         g;
    logic [7:0] x;
    logic [7:0] y;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[10];
    logic [7:0] y;
    logic       e;
    int         lat;
    int         got;
    int         cyc;
    int         s0;
    int         since3;
    int         nwait;
    logic [7:0] rx[N];
    bit         raised[N];
    logic [7:0] four_y[4];

    vecs[0] = '{0, 8'd0,   8'd0};
    vecs[1] = '{1, 8'd1,   8'd1};
    vecs[2] = '{2, 8'd8,   8'd2};
    vecs[3] = '{3, 8'd7,   8'd1};
    vecs[4] = '{1, 8'd26,  8'd2};
    vecs[5] = '{2, 8'd63,  8'd3};
    vecs[6] = '{0, 8'd124, 8'd4};
    vecs[7] = '{3, 8'd216, 8'd6};
    vecs[8] = '{1, 8'd215, 8'd5};
    vecs[9] = '{2, 8'd255, 8'd6};
    four_y  = '{8'd3, 8'd4, 8'd5, 8'd6};

    bus.req  = '0;
    bus.x_in = '0;
    reset    = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("in_reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("idle");

    // Single request, exactly one engine launch.
    s0 = eng_starts;
    serve_one(0, 8'd10, y, e, lat);
    check("single_y", 32'(y), 2);
    check("single_err", 32'(e), 0);
    repeat (3) @(negedge clk);
    check("single_starts", 32'(eng_starts - s0), 1);

    foreach (vecs[i]) begin
      rise_late = int'($urandom_range(0, 1));
      run_len   = int'($urandom_range(1, 5));
      serve_one(vecs[i].g, vecs[i].x, y, e, lat);
      check($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].y));
      check($sformatf("vec%0d_err", i), 32'(e), 0);
    end

    // All four at once from ptr 0.
    do_reset();
    set_x(0, 8'd27);
    set_x(1, 8'd64);
    set_x(2, 8'd125);
    set_x(3, 8'd255);
    bus.req = 4'hF;
    for (int k = 0; k < 4; k++) begin
      wait_ack_any(got, cyc);
      if (got >= 0) bus.req[got] = 1'b0;
      check($sformatf("all4_order%0d", k), 32'(got), 32'(k));
      if (k > 0) check($sformatf("all4_gap%0d", k), 32'(cyc), 2);
      wait_done(lat, y, e);
      check($sformatf("all4_y%0d", k), 32'(y), 32'(four_y[k]));
    end

    // Fairness with requester 3 held permanently.
    do_reset();
    set_x(0, 8'd30);
    set_x(1, 8'd100);
    set_x(3, 8'd200);
    bus.req = 4'b1011;
    since3 = 0;
    for (int s = 0; s < 9; s++) begin
      wait_ack_any(got, cyc);
      if (got == 0 || got == 1) bus.req[got] = 1'b0;
      since3++;
      if (got == 3) begin
        check("fair_gap_ok", 32'(since3 <= 3), 1);
        since3 = 0;
      end
      wait_done(lat, y, e);
      if (got == 0 || got == 1) bus.req[got] = 1'b1;
    end
    check("fair_final_gap", 32'(since3 <= 3), 1);
    bus.req = '0;
    repeat (6) @(negedge clk);

    // Engine stuck busy: timeout abort, then normal service.
    eng_stuck = 1'b1;
    exp_err   = 1'b1;
    serve_one(2, 8'd100, y, e, lat);
    check("timeout_err", 32'(e), 1);
    check("timeout_y", 32'(y), 0);
    check("timeout_latency", 32'(lat), TIMEOUT + 1);
    eng_stuck = 1'b0;
    exp_err   = 1'b0;
    nwait = 0;
    while (eng_busy && nwait < 20) begin
      @(negedge clk);
      nwait++;
    end
    check("engine_released", 32'(eng_busy), 0);
    serve_one(2, 8'd100, y, e, lat);
    check("after_timeout_y", 32'(y), 4);
    check("after_timeout_err", 32'(e), 0);

    // Randomized services with withdrawals.
    foreach (raised[i]) raised[i] = 1'b0;
    for (int it = 0; it < 40; it++) begin
      rise_late = int'($urandom_range(0, 1));
      run_len   = int'($urandom_range(1, 6));
      for (int i = 0; i < N; i++) begin
        if (!raised[i] && $urandom_range(0, 1) == 1) begin
          rx[i] = 8'($urandom_range(0, 255));
          set_x(i, rx[i]);
          raised[i]  = 1'b1;
          bus.req[i] = 1'b1;
        end
      end
      if (bus.req == 0) begin
        got = int'($urandom_range(0, N - 1));
        rx[got] = 8'($urandom_range(0, 255));
        set_x(got, rx[got]);
        raised[got]  = 1'b1;
        bus.req[got] = 1'b1;
      end
      wait_ack_any(got, cyc);
      if (got >= 0) begin
        bus.req[got] = 1'b0;
        raised[got]  = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        s0 = int'($urandom_range(0, N - 1));
        bus.req[s0] = 1'b0;
        raised[s0]  = 1'b0;
      end
      wait_done(lat, y, e);
      if (got >= 0) check("rand_y", 32'(y), 32'(cbrt_ref(rx[got])));
    end
    bus.req = '0;
    repeat (6) @(negedge clk);

    // Reset while the engine is running.
    rise_late = 0;
    run_len   = 8;
    serve_one(1, 8'd10, y, e, lat);
    set_x(0, 8'd64);
    bus.req[0] = 1'b1;
    wait_ack_any(got, cyc);
    bus.req[0] = 1'b0;
    nwait = 0;
    while (!bus.cr_busy && nwait < 10) begin
      @(negedge clk);
      nwait++;
    end
    @(negedge clk);
    check("pre_reset_busy", 32'(bus.cr_busy), 1);
    check("pre_reset_cr_x", 32'(bus.cr_x), 64);
    #1;
    reset = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    repeat (2) begin
      @(negedge clk);
      check("reset_no_done", 32'(bus.done), 0);
    end
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("post_reset_no_done", 32'(bus.done), 0);
    end
    serve_one(0, 8'd64, y, e, lat);
    check("post_reset_y", 32'(y), 4);
    check("post_reset_err", 32'(e), 0);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
